// File: rtl/ifetch_sequencer.sv
// ifetch_sequencer: issues four byte reads from PC, strobing one IR byte lane per returned byte,
// then pulses fetch_done (or fetch_err on a read timeout) and reports PC+4.
module ifetch_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic              ph1,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] PC,
    input  logic              MemReady,
    output logic              MemRead,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              IRWrite0,
    output logic              IRWrite1,
    output logic              IRWrite2,
    output logic              IRWrite3,
    output logic              busy,
    output logic              fetch_done,
    output logic              fetch_err,
    output logic [ADDR_W-1:0] PCPlus4
);
    localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, FETCH2, FETCH3, DONE} state_t;
    state_t            state, state_n;
    logic [ADDR_W-1:0] base;
    logic [WW-1:0]     wait_cnt, wait_n;
    logic              err_n, fetching, timeout;
    logic [1:0]        idx;
    assign timeout = (MAX_WAIT != 0) && (wait_cnt == WW'(MAX_WAIT - 1));
    assign idx     = 2'(state - FETCH0);
    // reset gates every combinational output so a mid-fetch reset cannot leak a strobe
    assign fetching   = reset && (state inside {FETCH0, FETCH1, FETCH2, FETCH3});
    assign MemRead    = fetching;
    assign MemAddr    = fetching ? base + ADDR_W'(idx) : '0;
    assign IRWrite0   = fetching && MemReady && (idx == 2'd0);
    assign IRWrite1   = fetching && MemReady && (idx == 2'd1);
    assign IRWrite2   = fetching && MemReady && (idx == 2'd2);
    assign IRWrite3   = fetching && MemReady && (idx == 2'd3);
    assign busy       = reset && (state != IDLE);
    assign fetch_done = reset && (state == DONE);
    always_ff @(posedge ph1) begin
        if (!reset) begin
            state     <= IDLE;
            base      <= '0;
            wait_cnt  <= '0;
            PCPlus4   <= '0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_n;
            fetch_err <= err_n;
            if (state == IDLE && start) base <= PC;
            if (state == FETCH3 && MemReady) PCPlus4 <= base + ADDR_W'(4);
        end
    end
    always_comb begin
        state_n = state;
        wait_n  = wait_cnt;
        err_n   = 1'b0;
        if (state == IDLE) begin
            state_n = start ? FETCH0 : IDLE;
            wait_n  = '0;
        end else if (state == DONE) begin
            state_n = IDLE;
        end else if (MemReady) begin
            state_n = (state == FETCH3) ? DONE : state_t'(state + 3'd1);
            wait_n  = '0;
        end else if (timeout) begin
            state_n = IDLE;
            wait_n  = '0;
            err_n   = 1'b1;
        end else begin
            wait_n = wait_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ifetch_sequencer.sv
// tb_ifetch_sequencer: table-driven per-cycle vectors plus hand-written wait/timeout sequences,
// with a byte memory and instruction register modelled around the sequencer.
module tb_ifetch_sequencer;
    logic       ph1 = 1'b0;
    logic       reset, start, MemReady;
    logic [7:0] PC, MemAddr, PCPlus4;
    logic       MemRead, IRWrite0, IRWrite1, IRWrite2, IRWrite3, busy, fetch_done, fetch_err;
    logic [7:0]  mem [256];
    logic [31:0] ir = '0;
    int checks = 0;
    int errors = 0;

    ifetch_sequencer #(.ADDR_W(8), .MAX_WAIT(15)) dut (
        .ph1(ph1), .reset(reset), .start(start), .PC(PC), .MemReady(MemReady),
        .MemRead(MemRead), .MemAddr(MemAddr),
        .IRWrite0(IRWrite0), .IRWrite1(IRWrite1), .IRWrite2(IRWrite2), .IRWrite3(IRWrite3),
        .busy(busy), .fetch_done(fetch_done), .fetch_err(fetch_err), .PCPlus4(PCPlus4)
    );

    always #5 ph1 = ~ph1;

    // byte 0 lands in the most significant lane of the instruction register
    always @(posedge ph1) begin
        if (IRWrite0) ir[31:24] <= mem[MemAddr];
        if (IRWrite1) ir[23:16] <= mem[MemAddr];
        if (IRWrite2) ir[15:8]  <= mem[MemAddr];
        if (IRWrite3) ir[7:0]   <= mem[MemAddr];
    end

    typedef struct {
        logic rst, st; logic [7:0] pc; logic rdy;
        logic rd; logic [7:0] addr; logic [3:0] irw; logic bsy, dn, er;
        logic [7:0] pc4; logic irc; logic [31:0] ir;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, st, input logic [7:0] pc, input logic rdy, rd,
                                input logic [7:0] addr, input logic [3:0] irw, input logic bsy, dn, er,
                                input logic [7:0] pc4, input logic irc, input logic [31:0] irv);
        vec_t v;
        v.rst = rst; v.st = st; v.pc = pc; v.rdy = rdy; v.rd = rd; v.addr = addr; v.irw = irw;
        v.bsy = bsy; v.dn = dn; v.er = er; v.pc4 = pc4; v.irc = irc; v.ir = irv;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    // start a fetch at pc, then drive MemReady from rdy bit c in cycle c after the start edge
    task automatic seq(input string tag, input logic [7:0] pc, input logic [31:0] rdy, input int n,
                       input int done_at, input int err_at, input logic [7:0] ea [24],
                       output logic [3:0] seen);
        seen = '0;
        start = 1'b1; PC = pc; MemReady = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 0; c < n; c++) begin
            MemReady = rdy[c];
            #4;
            chk({tag, "_addr"}, c, 32'(MemAddr), 32'(ea[c]));
            chk({tag, "_done"}, c, 32'(fetch_done), 32'(c == done_at));
            chk({tag, "_err"},  c, 32'(fetch_err),  32'(c == err_at));
            seen |= {IRWrite3, IRWrite2, IRWrite1, IRWrite0};
            tick();
        end
    endtask

    initial begin
        logic [7:0] ea [24];
        logic [3:0] seen;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB; mem[8'h12] = 8'hCC; mem[8'h13] = 8'hDD;
        //                 rst st pc    rdy rd addr   irw  bsy dn er pc4    irc ir
        tbl.push_back(mk(0, 1, 8'h10, 1, 0, 8'h00, 4'h0, 0, 0, 0, 8'h00, 0, '0));
        tbl.push_back(mk(0, 1, 8'h10, 1, 0, 8'h00, 4'h0, 0, 0, 0, 8'h00, 0, '0));
        tbl.push_back(mk(1, 0, 8'h10, 1, 0, 8'h00, 4'h0, 0, 0, 0, 8'h00, 0, '0));
        tbl.push_back(mk(1, 0, 8'h10, 1, 0, 8'h00, 4'h0, 0, 0, 0, 8'h00, 0, '0));
        tbl.push_back(mk(1, 1, 8'h10, 1, 0, 8'h00, 4'h0, 0, 0, 0, 8'h00, 0, '0));
        tbl.push_back(mk(1, 0, 8'h10, 1, 1, 8'h10, 4'h1, 1, 0, 0, 8'h00, 0, '0));
        tbl.push_back(mk(1, 0, 8'h10, 1, 1, 8'h11, 4'h2, 1, 0, 0, 8'h00, 0, '0));
        tbl.push_back(mk(1, 0, 8'h10, 1, 1, 8'h12, 4'h4, 1, 0, 0, 8'h00, 0, '0));
        tbl.push_back(mk(1, 0, 8'h10, 1, 1, 8'h13, 4'h8, 1, 0, 0, 8'h00, 0, '0));
        tbl.push_back(mk(1, 0, 8'h10, 1, 0, 8'h00, 4'h0, 1, 1, 0, 8'h14, 1, 32'hAABBCCDD));
        tbl.push_back(mk(1, 0, 8'h10, 1, 0, 8'h00, 4'h0, 0, 0, 0, 8'h14, 0, '0));
        tbl.push_back(mk(1, 1, 8'hFE, 1, 0, 8'h00, 4'h0, 0, 0, 0, 8'h14, 0, '0));
        tbl.push_back(mk(1, 0, 8'hFE, 1, 1, 8'hFE, 4'h1, 1, 0, 0, 8'h14, 0, '0));
        tbl.push_back(mk(1, 0, 8'hFE, 1, 1, 8'hFF, 4'h2, 1, 0, 0, 8'h14, 0, '0));
        tbl.push_back(mk(1, 0, 8'hFE, 1, 1, 8'h00, 4'h4, 1, 0, 0, 8'h14, 0, '0));
        tbl.push_back(mk(1, 0, 8'hFE, 1, 1, 8'h01, 4'h8, 1, 0, 0, 8'h14, 0, '0));
        tbl.push_back(mk(1, 0, 8'hFE, 1, 0, 8'h00, 4'h0, 1, 1, 0, 8'h02, 1, 32'hA4A55A5B));
        tbl.push_back(mk(1, 0, 8'hFE, 1, 0, 8'h00, 4'h0, 0, 0, 0, 8'h02, 0, '0));
        tbl.push_back(mk(1, 1, 8'h20, 1, 0, 8'h00, 4'h0, 0, 0, 0, 8'h02, 0, '0));
        tbl.push_back(mk(1, 0, 8'h20, 1, 1, 8'h20, 4'h1, 1, 0, 0, 8'h02, 0, '0));
        tbl.push_back(mk(1, 1, 8'h40, 1, 1, 8'h21, 4'h2, 1, 0, 0, 8'h02, 0, '0));
        tbl.push_back(mk(1, 0, 8'h40, 1, 1, 8'h22, 4'h4, 1, 0, 0, 8'h02, 0, '0));
        tbl.push_back(mk(1, 0, 8'h40, 1, 1, 8'h23, 4'h8, 1, 0, 0, 8'h02, 0, '0));
        tbl.push_back(mk(1, 1, 8'h40, 1, 0, 8'h00, 4'h0, 1, 1, 0, 8'h24, 1, 32'h7A7B7879));
        tbl.push_back(mk(1, 0, 8'h40, 1, 0, 8'h00, 4'h0, 0, 0, 0, 8'h24, 0, '0));
        tbl.push_back(mk(1, 0, 8'h40, 1, 0, 8'h00, 4'h0, 0, 0, 0, 8'h24, 0, '0));
        tbl.push_back(mk(1, 1, 8'h30, 1, 0, 8'h00, 4'h0, 0, 0, 0, 8'h24, 0, '0));
        tbl.push_back(mk(1, 0, 8'h30, 1, 1, 8'h30, 4'h1, 1, 0, 0, 8'h24, 0, '0));
        tbl.push_back(mk(1, 0, 8'h30, 1, 1, 8'h31, 4'h2, 1, 0, 0, 8'h24, 0, '0));
        tbl.push_back(mk(0, 0, 8'h30, 1, 0, 8'h00, 4'h0, 0, 0, 0, 8'h24, 0, '0));
        tbl.push_back(mk(1, 0, 8'h30, 0, 0, 8'h00, 4'h0, 0, 0, 0, 8'h00, 1, 32'h6A6B7879));

        reset = 1'b0; start = 1'b0; PC = '0; MemReady = 1'b0;
        tick();
        foreach (tbl[i]) begin
            reset = tbl[i].rst; start = tbl[i].st; PC = tbl[i].pc; MemReady = tbl[i].rdy;
            #4;
            chk("memread", i, 32'(MemRead), 32'(tbl[i].rd));
            chk("memaddr", i, 32'(MemAddr), 32'(tbl[i].addr));
            chk("irwrite", i, 32'({IRWrite3, IRWrite2, IRWrite1, IRWrite0}), 32'(tbl[i].irw));
            chk("busy", i, 32'(busy), 32'(tbl[i].bsy));
            chk("fetch_done", i, 32'(fetch_done), 32'(tbl[i].dn));
            chk("fetch_err", i, 32'(fetch_err), 32'(tbl[i].er));
            chk("pcplus4", i, 32'(PCPlus4), 32'(tbl[i].pc4));
            if (tbl[i].irc) chk("ir", i, ir, tbl[i].ir);
            tick();
        end

        // wait states: two before byte 1, one before byte 3; DONE three cycles later than zero-wait
        ea = '{default: 8'h00};
        ea[0] = 8'h10; ea[1] = 8'h11; ea[2] = 8'h11; ea[3] = 8'h11; ea[4] = 8'h12; ea[5] = 8'h13; ea[6] = 8'h13;
        seq("wait", 8'h10, 32'h59, 9, 7, -1, ea, seen);
        chk("wait_strobes", 0, 32'(seen), 32'hF);
        chk("wait_ir", 0, ir, 32'hAABBCCDD);
        chk("wait_pc4", 0, 32'(PCPlus4), 32'h14);

        // timeout: MemReady low for 15 cycles in FETCH2
        ea = '{default: 8'h00};
        ea[0] = 8'h50; ea[1] = 8'h51;
        for (int c = 2; c <= 16; c++) ea[c] = 8'h52;
        seq("tmo", 8'h50, 32'h3, 19, -1, 17, ea, seen);
        chk("tmo_strobes", 0, 32'(seen), 32'h3);
        chk("tmo_pc4", 0, 32'(PCPlus4), 32'h14);
        #4;
        chk("tmo_busy", 0, 32'(busy), 32'h0);
        tick();

        // MemReady arriving on the 15th waiting cycle beats the timeout
        ea = '{default: 8'h00};
        ea[0] = 8'h40; ea[1] = 8'h41;
        for (int c = 2; c <= 16; c++) ea[c] = 8'h42;
        ea[17] = 8'h43;
        seq("prio", 8'h40, 32'h30003, 20, 18, -1, ea, seen);
        chk("prio_strobes", 0, 32'(seen), 32'hF);
        chk("prio_ir", 0, ir, 32'h1A1B1819);
        chk("prio_pc4", 0, 32'(PCPlus4), 32'h44);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ifetch_sequencer.md
# ifetch_sequencer

Fetch sequencer for the multicycle core's 8-bit memory path. On a fetch request from main control it issues four consecutive byte reads starting at the current PC. For each returned byte it asserts exactly one of IRWrite0..IRWrite3 in the cycle MemData is valid, so the downstream instruction register assembles the 32-bit word. It then signals completion (or a timeout error) and reports PC+4.

## Interface
Parameters:
- ADDR_W, 8, width of PC and memory address.
- MAX_WAIT, 15, max consecutive cycles a byte read may wait for MemReady; 0 disables timeout.

Ports:
- ph1  in  1  single clock; all state updates on posedge ph1.
- reset  in  1  synchronous, active-low reset; sampled on posedge ph1 (0 = reset).
- start  in  1  fetch request from main control; honoured only in IDLE.
- PC  in  ADDR_W  base byte address; sampled when start is accepted.
- MemReady  in  1  memory has valid MemData this cycle for the current MemAddr.
- MemRead  out  1  read request, high in FETCH0..FETCH3.
- MemAddr  out  ADDR_W  byte address = base + n in FETCHn, else 0.
- IRWrite0..IRWrite3  out  1 each  byte-capture strobes to the instruction register; at most one high per cycle.
- busy  out  1  high in any state other than IDLE.
- fetch_done  out  1  one-cycle pulse; the assembled instruction is valid in the IR.
- fetch_err  out  1  one-cycle pulse; a byte read timed out and the fetch was abandoned.
- PCPlus4  out  ADDR_W  base + 4 (mod 2^ADDR_W); registered when fetch_done is set, held until the next completed fetch.

## Operation
- States: IDLE, FETCH0, FETCH1, FETCH2, FETCH3, DONE.
- IDLE: if start=1, latch base <= PC, clear wait_cnt, go to FETCH0. Otherwise stay in IDLE.
- FETCHn:
  - MemRead=1 and MemAddr=base+n (ADDR_W bits, wraps modulo 2^ADDR_W).
  - IRWriten = MemReady. This strobe is combinational from state and MemReady.
  - If MemReady=1, clear wait_cnt and go to FETCH(n+1), or to DONE from FETCH3.
  - If MemReady=0 and MAX_WAIT≠0 and wait_cnt == MAX_WAIT−1, go to IDLE and set fetch_err=1 for the next cycle.
  - Otherwise increment wait_cnt and stay.
  - MemReady=1 takes priority over timeout in the same cycle.
- DONE: fetch_done=1 for this cycle; PCPlus4 was loaded on the entry edge; go to IDLE.
- start is ignored (not queued) while busy, including in DONE.
- wait_cnt width is clog2(MAX_WAIT+1), minimum 1.
- No partial-byte rollback: after a timeout the IR holds whatever bytes were already written.

## Timing
- Reset (reset=0 at an edge):
  - state ← IDLE; base, wait_cnt, PCPlus4 ← 0; fetch_err ← 0.
  - While reset=0, MemRead, MemAddr, IRWrite0..3, busy and fetch_done are forced 0 combinationally.
  - Reset mid-fetch therefore never produces a stray IRWrite, even in the reset cycle itself.
- Zero-wait memory (MemReady held 1), start sampled at edge E0:
  - FETCH0..FETCH3 occupy the cycles after E0..E3.
  - The IR captures bytes 0..3 at edges E1..E4.
  - DONE occupies the cycle after E4, with fetch_done=1 and the Instruction valid.
  - IDLE from E5.
  - Minimum start-to-start spacing is 6 cycles.
- Each wait cycle in FETCHn adds exactly one cycle of latency.
- Timeout: in FETCHn, if MemReady stays 0 for MAX_WAIT consecutive cycles, the state is IDLE after the MAX_WAIT-th edge, with fetch_err=1 for exactly one cycle and no fetch_done.
- MemAddr and MemRead are stable across wait cycles.

## Test plan
- Reset check: reset=0 for 2 cycles while start=1 and MemReady=1 → all outputs 0, state IDLE. Release reset → outputs remain idle until start.
- Zero-wait fetch: PC=0x10, bytes 0xAA, 0xBB, 0xCC, 0xDD → MemAddr steps 0x10..0x13, with one IRWrite per cycle in order 0..3. fetch_done occurs 5 cycles after the start edge, the IR reads 0xAABBCCDD and PCPlus4=0x14.
- Wait states: 2 idle cycles before byte 1 and 1 before byte 3 → MemAddr holds 0x11 and 0x13 across the waits, and fetch_done arrives 3 cycles later than in the zero-wait case.
- Wrap-around: PC=0xFE → MemAddr sequence 0xFE, 0xFF, 0x00, 0x01 and PCPlus4=0x02.
- Timeout and priority:
  - MAX_WAIT=15, MemReady low for 15 cycles in FETCH2 → fetch_err pulse, IDLE, no fetch_done, IRWrite2/3 never asserted.
  - Repeat with MemReady rising on the 15th cycle → no error, fetch completes.
- Start while busy / reset mid-fetch:
  - start re-asserted during FETCH1 and DONE is ignored; the next fetch begins only from IDLE.
  - reset=0 in FETCH2 with MemReady=1 → IRWrite2 stays 0 and the next state is IDLE.
